// File: rtl/de_pkg.sv
// de_pkg: shared decode-stage constants and helpers.
//   DE_NREGS / DE_REGNOBITS : architectural register file geometry
//   DE_CNTBITS              : default scoreboard counter width
//   CNT_MAX(cntbits)        : largest value a cntbits-wide counter may hold
//   DEC_BITS(nwb)           : width needed to count up to nwb retirements
package de_pkg;

  localparam int DE_NREGS     = 32;
  localparam int DE_REGNOBITS = 5;
  localparam int DE_CNTBITS   = 2;

  function automatic int CNT_MAX(input int cntbits);
    return (1 << cntbits) - 1;
  endfunction

  function automatic int DEC_BITS(input int nwb);
    return $clog2(nwb + 1);
  endfunction

endpackage

// File: rtl/de_sb_counter.sv
// de_sb_counter: one per-register in-flight writer counter.
//   clk, reset   : clock, asynchronous active-high reset
//   inc_i        : one new writer issued this cycle
//   dec_i        : number of writeback ports retiring this register now
//   cnt_o        : current (registered) count
//   cnt_d_o      : count that will be loaded on the next posedge
//   underflow_o  : more retirements than writers this cycle (count clamps to 0)
module de_sb_counter
  import de_pkg::*;
#(
  parameter int CNTBITS = DE_CNTBITS,
  parameter int DECBITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_i,
  input  logic [DECBITS-1:0] dec_i,
  output logic [CNTBITS-1:0] cnt_o,
  output logic [CNTBITS-1:0] cnt_d_o,
  output logic               underflow_o
);

  // Wide enough for count+inc and for dec without overflow.
  localparam int EW = ((CNTBITS + 1 > DECBITS) ? CNTBITS + 1 : DECBITS) + 1;
  localparam logic [EW-1:0] MAXV = EW'(CNT_MAX(CNTBITS));

  logic [CNTBITS-1:0] cnt_q;
  logic [EW-1:0]      up_w;
  logic [EW-1:0]      dec_w;
  logic [EW-1:0]      diff_w;
  logic               uf;

  // Clamp to 0 on underflow and to MAX on (unreachable in normal use) overflow.
  function automatic logic [CNTBITS-1:0] clamp_cnt(input logic [EW-1:0] v,
                                                   input logic uf_in);
    if (uf_in)          return '0;
    else if (v > MAXV)  return MAXV[CNTBITS-1:0];
    else                return v[CNTBITS-1:0];
  endfunction

  assign up_w   = EW'(cnt_q) + EW'(inc_i);
  assign dec_w  = EW'(dec_i);
  assign uf     = dec_w > up_w;
  assign diff_w = up_w - dec_w;

  assign cnt_d_o     = clamp_cnt(diff_w, uf);
  assign cnt_o       = cnt_q;
  assign underflow_o = uf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d_o;
  end

endmodule

// File: rtl/de_scoreboard.sv
// de_scoreboard: decode-stage register scoreboard.
// Tracks outstanding writes per architectural register and produces the DE
// stall and issue-fire qualifier. Register 0 is never tracked.
//   clk, reset            : clock, asynchronous active-high reset
//   issue_valid/_wr_reg   : instruction in DE, and whether it writes rd
//   issue_rd              : destination register
//   src_valid/src_regno   : NSRC source operands, operand i at [i*REGNOBITS +: REGNOBITS]
//   flush                 : redirect, kills the DE instruction this cycle
//   wb_valid/wb_regno     : NWB writeback ports retiring register writes
//   stall, issue_fire     : combinational DE control
//   pending_mask          : registered, bit r set while register r has writers in flight
//   outstanding           : registered total of all counters
//   err_underflow         : registered sticky underflow flag
// Build option: define DE_SB_WB_BYPASS_EN when the register file writes on
// negedge, so a source whose last pending writers retire this cycle does not stall.
module de_scoreboard
  import de_pkg::*;
#(
  parameter int NREGS     = DE_NREGS,
  parameter int REGNOBITS = DE_REGNOBITS,
  parameter int NSRC      = 2,
  parameter int NWB       = 1,
  parameter int CNTBITS   = DE_CNTBITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic                        issue_wr_reg,
  input  logic [REGNOBITS-1:0]        issue_rd,
  input  logic [NSRC-1:0]             src_valid,
  input  logic [NSRC*REGNOBITS-1:0]   src_regno,
  input  logic                        flush,
  input  logic [NWB-1:0]              wb_valid,
  input  logic [NWB*REGNOBITS-1:0]    wb_regno,
  output logic                        stall,
  output logic                        issue_fire,
  output logic [NREGS-1:0]            pending_mask,
  output logic [REGNOBITS+CNTBITS-1:0] outstanding,
  output logic                        err_underflow
);

  localparam int MAXC    = CNT_MAX(CNTBITS);
  localparam int DECBITS = DEC_BITS(NWB);
  localparam int OUTW    = REGNOBITS + CNTBITS;
`ifdef DE_SB_WB_BYPASS_EN
  localparam int CW      = (CNTBITS > DECBITS) ? CNTBITS : DECBITS;
`endif

  logic [NREGS-1:0][CNTBITS-1:0] cnt_q;
  logic [NREGS-1:0][CNTBITS-1:0] cnt_d;
  logic [NREGS-1:1][DECBITS-1:0] dec_r;
  logic [NREGS-1:0]              uf_r;

  logic [NREGS-1:0]     pending_mask_q, pending_mask_d;
  logic [OUTW-1:0]      outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic                 hazard;
  logic                 full;
  logic [REGNOBITS-1:0] sreg;

  // Number of writeback ports retiring register rn this cycle.
  function automatic logic [DECBITS-1:0] wb_hits(input logic [REGNOBITS-1:0] rn);
    logic [DECBITS-1:0] n;
    n = '0;
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p] && wb_regno[p*REGNOBITS +: REGNOBITS] == rn) n = n + DECBITS'(1);
    end
    return n;
  endfunction

  always_comb begin
    for (int r = 1; r < NREGS; r++) dec_r[r] = wb_hits(REGNOBITS'(r));
  end

  // Register 0 is hardwired: never counts, never underflows.
  assign cnt_q[0] = '0;
  assign cnt_d[0] = '0;
  assign uf_r[0]  = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    logic inc;
    assign inc = issue_fire & issue_wr_reg & (issue_rd == REGNOBITS'(r));
    de_sb_counter #(
      .CNTBITS (CNTBITS),
      .DECBITS (DECBITS)
    ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .inc_i       (inc),
      .dec_i       (dec_r[r]),
      .cnt_o       (cnt_q[r]),
      .cnt_d_o     (cnt_d[r]),
      .underflow_o (uf_r[r])
    );
  end

  always_comb begin
    hazard = 1'b0;
    sreg   = '0;
    for (int s = 0; s < NSRC; s++) begin
      sreg = src_regno[s*REGNOBITS +: REGNOBITS];
      if (src_valid[s] && sreg != '0 && cnt_q[sreg] != '0
`ifdef DE_SB_WB_BYPASS_EN
          // All pending writers retire now; the negedge write lands before the read.
          && CW'(cnt_q[sreg]) != CW'(wb_hits(sreg))
`endif
         ) hazard = 1'b1;
    end
    // A saturated counter cannot accept another writer, so hold the issue.
    full  = issue_wr_reg && issue_rd != '0 && cnt_q[issue_rd] == CNTBITS'(MAXC);
    stall = issue_valid & (hazard | full);
  end

  assign issue_fire = issue_valid & ~stall & ~flush;

  // Aggregates are built from next-state counts so they track the counters
  // on the same posedge.
  always_comb begin
    pending_mask_d = '0;
    outstanding_d  = '0;
    for (int r = 0; r < NREGS; r++) begin
      pending_mask_d[r] = cnt_d[r] != '0;
      outstanding_d     = outstanding_d + OUTW'(cnt_d[r]);
    end
    err_d = err_q | (|uf_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_mask_q <= '0;
      outstanding_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      pending_mask_q <= pending_mask_d;
      outstanding_q  <= outstanding_d;
      err_q          <= err_d;
    end
  end

  assign pending_mask  = pending_mask_q;
  assign outstanding   = outstanding_q;
  assign err_underflow = err_q;

endmodule
